piso_tx: RTL and testbench

//  Parallel-in serial-out transmitter. It is the consumer side of the 16-bit

---
 rtl/piso_tx.sv | 110 +++++++++++
 tb/tb_piso_tx.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures a word on ld, shifts it out one bit
// per clock with an optional trailing even-parity bit, and reports busy/done.
module piso_tx #(
  parameter int WIDTH     = 16,
  parameter int LSB_FIRST = 0,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] data_in,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] FRAME_LEN = CW'(WIDTH + PARITY);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             par, par_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             sout_n, valid_n, busy_n, done_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      par        <= 1'b0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      par        <= par_n;
      cnt        <= cnt_n;
      sout       <= sout_n;
      sout_valid <= valid_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // cnt holds the number of frame bits already placed on sout; the shift register
  // keeps the bit currently on sout at its outgoing end, so the next bit is one in.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    par_n   = par;
    cnt_n   = cnt;
    sout_n  = 1'b0;
    valid_n = 1'b0;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        cnt_n  = '0;
        if (ld) begin
          state_n = SHIFT;
          shreg_n = data_in;
          par_n   = ^data_in;
          sout_n  = (LSB_FIRST != 0) ? data_in[0] : data_in[WIDTH-1];
          valid_n = 1'b1;
          busy_n  = 1'b1;
          cnt_n   = CW'(1);
        end
      end
      SHIFT: begin
        if (cnt == FRAME_LEN) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          valid_n = 1'b1;
          cnt_n   = cnt + CW'(1);
          if (cnt < DATA_LAST) begin
            if (LSB_FIRST != 0) begin
              shreg_n = shreg >> 1;
              sout_n  = shreg[1];
            end else begin
              shreg_n = shreg << 1;
              sout_n  = shreg[WIDTH-2];
            end
          end else begin
            sout_n = par;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first instance without parity and an
// LSB-first instance with parity, checked against hand-computed bit sequences.
module tb_piso_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ld_a = 1'b0, ld_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        sout_a, valid_a, busy_a, done_a;
  logic        sout_b, valid_b, busy_b, done_b;

  int checks = 0;
  int errors = 0;

  piso_tx #(.WIDTH(16), .LSB_FIRST(0), .PARITY(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ld(ld_a), .data_in(data_a),
    .sout(sout_a), .sout_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  piso_tx #(.WIDTH(16), .LSB_FIRST(1), .PARITY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ld(ld_b), .data_in(data_b),
    .sout(sout_b), .sout_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sel, input logic l, input logic [15:0] d);
    if (sel) begin
      ld_b = l;
      data_b = d;
    end else begin
      ld_a = l;
      data_a = d;
    end
  endtask

  // seq holds the frame in transmission order starting at bit 16; cycle k after
  // the load edge must show seq[17-k]. hold keeps ld high and swaps in next_word.
  task automatic checkSerial(input string name, input bit sel, input logic [16:0] seq,
                             input int flen, input bit hold, input logic [15:0] next_word,
                             input int inject);
    logic s, v, b, d;
    for (int k = 1; k <= flen + 2; k++) begin
      step();
      if (hold) begin
        if (k == 2) applyStimulus(sel, 1'b1, next_word);
      end else begin
        if (k == 1) applyStimulus(sel, 1'b0, ~(sel ? data_b : data_a));
        if (k == inject) applyStimulus(sel, 1'b1, 16'h1234);
        if (k == inject + 1) applyStimulus(sel, 1'b0, 16'h1234);
      end
      s = sel ? sout_b : sout_a;
      v = sel ? valid_b : valid_a;
      b = sel ? busy_b : busy_a;
      d = sel ? done_b : done_a;
      if (k <= flen) begin
        checkOutput($sformatf("%s bit%0d sout", name, k), 32'(s), 32'(seq[17-k]));
        checkOutput($sformatf("%s bit%0d valid/busy/done", name, k), {29'd0, v, b, d}, 32'b110);
      end else if (k == flen + 1) begin
        checkOutput($sformatf("%s done cycle sout/valid/busy/done", name), {28'd0, s, v, b, d}, 32'b0011);
      end else begin
        checkOutput($sformatf("%s idle cycle sout/valid/busy/done", name), {28'd0, s, v, b, d}, 32'b0000);
      end
    end
    if (!hold) begin
      step();
      v = sel ? valid_b : valid_a;
      b = sel ? busy_b : busy_a;
      checkOutput($sformatf("%s no restart valid/busy", name), {30'd0, v, b}, 32'b00);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Asynchronous reset asserted between edges must clear outputs immediately.
    #7 rst_n = 1'b0;
    #1;
    checkOutput("reset async a", {28'd0, sout_a, valid_a, busy_a, done_a}, 32'd0);
    checkOutput("reset async b", {28'd0, sout_b, valid_b, busy_b, done_b}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("idle no ld a", {28'd0, sout_a, valid_a, busy_a, done_a}, 32'd0);
      checkOutput("idle no ld b", {28'd0, sout_b, valid_b, busy_b, done_b}, 32'd0);
    end

    applyStimulus(1'b0, 1'b1, 16'hA5C3);
    checkSerial("msb_a5c3", 1'b0, {16'b1010_0101_1100_0011, 1'b0}, 16, 1'b0, 16'h0, 0);

    applyStimulus(1'b1, 1'b1, 16'h0001);
    checkSerial("lsb_par_0001", 1'b1, 17'b1_0000_0000_0000_0001, 17, 1'b0, 16'h0, 0);

    applyStimulus(1'b0, 1'b1, 16'hFFFF);
    checkSerial("ignore_ld_ffff", 1'b0, {16'b1111_1111_1111_1111, 1'b0}, 16, 1'b0, 16'h0, 5);

    // Drop rst_n mid-clock after the seventh bit of A5C3 (1010_010).
    applyStimulus(1'b0, 1'b1, 16'hA5C3);
    for (int k = 1; k <= 7; k++) begin
      logic [6:0] first7;
      first7 = 7'b1010_010;
      step();
      if (k == 1) applyStimulus(1'b0, 1'b0, 16'h0000);
      checkOutput($sformatf("pre_reset bit%0d", k), 32'(sout_a), 32'(first7[7-k]));
    end
    #3 rst_n = 1'b0;
    #1;
    checkOutput("mid_frame reset valid/busy/done", {29'd0, valid_a, busy_a, done_a}, 32'd0);
    checkOutput("mid_frame reset sout", 32'(sout_a), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("held reset valid/busy", {30'd0, valid_a, busy_a}, 32'd0);
    #2 rst_n = 1'b1;
    step();
    checkOutput("post_reset idle", {28'd0, sout_a, valid_a, busy_a, done_a}, 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h8001);
    checkSerial("after_reset_8001", 1'b0, {16'b1000_0000_0000_0001, 1'b0}, 16, 1'b0, 16'h0, 0);

    // ld held high: back-to-back frames every 18 cycles with alternating data.
    applyStimulus(1'b0, 1'b1, 16'hAAAA);
    checkSerial("hold_aaaa_1", 1'b0, {16'b1010_1010_1010_1010, 1'b0}, 16, 1'b1, 16'h5555, 0);
    checkSerial("hold_5555", 1'b0, {16'b0101_0101_0101_0101, 1'b0}, 16, 1'b1, 16'hAAAA, 0);
    checkSerial("hold_aaaa_2", 1'b0, {16'b1010_1010_1010_1010, 1'b0}, 16, 1'b1, 16'hAAAA, 0);
    applyStimulus(1'b0, 1'b0, 16'h0000);
    step();
    checkOutput("hold released idle", {28'd0, sout_a, valid_a, busy_a, done_a}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
